crc_serial_tx: RTL and testbench
================================

CRC_SERIAL_TX -- requirements
Module: crc_serial_tx

Interface
REQ-001 Parameter: width, 8, byte/CRC width in bits.
REQ-002 Parameter: poly, 8'h07, CRC generator polynomial (implicit x^width term).
REQ-003 Parameter: seed, 8'h00, CRC register value loaded at frame start.
REQ-004 I_clk  input  1  divided clock (O_div_clk of the clock divider); all logic on rising edge.
REQ-005 I_rst  input  1  asynchronous, active-high reset.
REQ-006 I_data  input  width  parallel data byte.
REQ-007 I_valid  input  1  I_data/I_last valid.
REQ-008 I_last  input  1  byte is last of frame; sampled with the byte.
REQ-009 O_ready  output  1  block accepts a byte this cycle.
REQ-010 O_ser  output  1  serial bit, MSB first.
REQ-011 O_ser_en  output  1  O_ser carries a valid bit this cycle.
REQ-012 O_crc_phase  output  1  O_ser carries a CRC bit.
REQ-013 O_busy  output  1  state is not IDLE.
REQ-014 O_frame_done  output  1  one-cycle pulse on final CRC bit.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, HOLD and CRC.
REQ-016 A byte SHALL be accepted on a rising edge where I_valid && O_ready; I_valid without O_ready SHALL be ignored, with no side effects.
REQ-017 O_ready SHALL be combinational: 1 in IDLE; 1 in HOLD; 1 in SHIFT only when bit_cnt==width-1 and the stored last flag is 0; 0 otherwise, including in CRC.
REQ-018 IDLE accept: load shift register with I_data, store I_last, load CRC register with seed, clear bit_cnt, go to SHIFT.
REQ-019 SHIFT: O_ser = shift-register MSB, O_ser_en=1, O_crc_phase=0; first bit appears in the cycle after acceptance (1-cycle latency).
REQ-020 Per SHIFT cycle, with b = O_ser and fb = crc[width-1]^b: crc <= {crc[width-2:0],0} ^ (fb ? poly : 0); shift register shifts left; bit_cnt increments.
REQ-021 At bit_cnt==width-1 in SHIFT, the next state SHALL be:
- CRC, if the last flag is 1;
- SHIFT, if a new byte is accepted: load it, clear bit_cnt, keep crc running, no idle bit between bytes;
- HOLD otherwise.
REQ-022 HOLD: O_ser_en=0, O_ser=0, crc held; an accepted byte SHALL load as in REQ-021 and go to SHIFT.
REQ-023 CRC: for width cycles, O_ser = crc[width-1], O_ser_en=1, O_crc_phase=1; crc shifts left with zero fill; bit_cnt counts 0..width-1.
REQ-024 O_frame_done SHALL be 1 during the CRC cycle with bit_cnt==width-1; next state IDLE.
REQ-025 There SHALL be at least one IDLE cycle between frames: a new frame is accepted no earlier than the first cycle after O_frame_done.
REQ-026 Outside SHIFT/CRC: O_ser=0, O_ser_en=0, O_crc_phase=0.
REQ-027 bit_cnt SHALL be $clog2(width)+1 bits wide, with no wrap beyond width-1.
REQ-028 A one-byte frame SHALL take exactly 2*width serial cycles.

Reset
REQ-029 I_rst high SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, crc=seed, shift register=0, bit_cnt=0, last flag=0;
- O_ser=0, O_ser_en=0, O_crc_phase=0, O_busy=0, O_frame_done=0, O_ready=1.
REQ-030 No byte SHALL be accepted while I_rst is high.
REQ-031 Reset mid-frame (SHIFT, HOLD or CRC) SHALL abandon the frame, with no CRC emitted; the first accept after release starts a fresh frame from seed.

Verification
REQ-032 Single byte 8'h31, I_last=1, defaults -> serial 0,0,1,1,0,0,0,1 then CRC 8'h97 (1,0,0,1,0,1,1,1) with O_crc_phase=1; O_frame_done on the 16th bit; O_ready=0 throughout.
REQ-033 "123456789" (8'h31..8'h39) back-to-back, last on 8'h39 -> 72 contiguous data bits with O_ser_en never low, then CRC 8'hF4.
REQ-034 Bytes 8'h01 and 8'h02 with I_valid low for 3 cycles in between -> 3 HOLD cycles with O_ser_en=0 and O_ready=1; CRC equals that of the contiguous 16'h0102.
REQ-035 Assert I_rst during CRC bit 3 -> all outputs at reset values immediately; frame 8'h01/last -> CRC 8'h07, unaffected by the aborted frame.
REQ-036 I_valid held high continuously with single-byte last frames -> exactly one IDLE cycle between frames; each frame lasts 16 bits.

Source files
------------

// File: rtl/crc_serial_tx.sv
// crc_serial_tx: serialises parallel bytes MSB first and appends the running CRC of the frame.
// Bytes chain back-to-back without gaps; a last-flagged byte is followed by width CRC bits.
module crc_serial_tx #(
   parameter int               width = 8,
   parameter logic [width-1:0] poly  = 8'h07,
   parameter logic [width-1:0] seed  = 8'h00
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic [width-1:0] I_data,
   input  logic             I_valid,
   input  logic             I_last,
   output logic             O_ready,
   output logic             O_ser,
   output logic             O_ser_en,
   output logic             O_crc_phase,
   output logic             O_busy,
   output logic             O_frame_done
);
   localparam int            CW       = $clog2(width) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, CRC} state_t;

   state_t           state_q;
   logic [width-1:0] sr_q;
   logic [width-1:0] crc_q;
   logic [CW-1:0]    cnt_q;
   logic             last_q;
   logic             at_end;
   logic             accept;
   logic             fb;
   logic [width-1:0] crc_d;

   assign at_end  = cnt_q == LAST_BIT;
   // a follow-on byte may only be taken on the final data bit of a non-last byte
   assign O_ready = state_q == IDLE || state_q == HOLD ||
                    (state_q == SHIFT && at_end && !last_q);
   assign accept  = I_valid && O_ready;
   assign fb      = crc_q[width-1] ^ sr_q[width-1];
   assign crc_d   = {crc_q[width-2:0], 1'b0} ^ (fb ? poly : '0);

   assign O_ser        = state_q == SHIFT ? sr_q[width-1] :
                         state_q == CRC   ? crc_q[width-1] : 1'b0;
   assign O_ser_en     = state_q == SHIFT || state_q == CRC;
   assign O_crc_phase  = state_q == CRC;
   assign O_busy       = state_q != IDLE;
   assign O_frame_done = state_q == CRC && at_end;

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         crc_q   <= seed;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sr_q    <= I_data;
                  last_q  <= I_last;
                  crc_q   <= seed;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               crc_q <= crc_d;
               if (!at_end) begin
                  sr_q  <= sr_q << 1;
                  cnt_q <= cnt_q + CW'(1);
               end else if (last_q) begin
                  cnt_q   <= '0;
                  state_q <= CRC;
               end else if (accept) begin
                  sr_q   <= I_data;
                  last_q <= I_last;
                  cnt_q  <= '0;
               end else begin
                  sr_q    <= sr_q << 1;
                  cnt_q   <= '0;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (accept) begin
                  sr_q    <= I_data;
                  last_q  <= I_last;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            CRC: begin
               crc_q <= crc_q << 1;
               if (at_end) begin
                  cnt_q   <= '0;
                  last_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_crc_serial_tx.sv
// tb_crc_serial_tx: directed frames with hand-computed CRC-8 (poly 07) results, scoreboard-checked.
module tb_crc_serial_tx;
   logic       I_clk;
   logic       I_rst;
   logic [7:0] I_data;
   logic       I_valid;
   logic       I_last;
   logic       O_ready;
   logic       O_ser;
   logic       O_ser_en;
   logic       O_crc_phase;
   logic       O_busy;
   logic       O_frame_done;

   crc_serial_tx dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_data(I_data), .I_valid(I_valid), .I_last(I_last),
      .O_ready(O_ready), .O_ser(O_ser), .O_ser_en(O_ser_en), .O_crc_phase(O_crc_phase),
      .O_busy(O_busy), .O_frame_done(O_frame_done)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   logic [2:0] exp_q[$];
   int         done_t[$];
   int         cyc = 0;
   int         hold_cnt = 0;
   int         checks = 0;
   int         fails = 0;
   int         m_checks = 0;
   int         m_fails = 0;

   always @(posedge I_clk) cyc <= cyc + 1;

   // monitor: every serial bit must match the next expected {ser, crc_phase, frame_done}
   always @(negedge I_clk) begin
      if (!I_rst) begin
         if (O_frame_done) done_t.push_back(cyc);
         if (O_busy && !O_ser_en && O_ready) hold_cnt++;
         if (O_ser_en) begin
            logic [2:0] e;
            m_checks++;
            if (exp_q.size() == 0) begin
               m_fails++;
               $display("FAIL unexpected_bit: got {ser,crc,done}=%b, required no bit at cycle %0d",
                        {O_ser, O_crc_phase, O_frame_done}, cyc);
            end else begin
               e = exp_q.pop_front();
               if ({O_ser, O_crc_phase, O_frame_done} !== e) begin
                  m_fails++;
                  $display("FAIL serial_bit: got {ser,crc,done}=%b, required %b at cycle %0d",
                           {O_ser, O_crc_phase, O_frame_done}, e, cyc);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ser"}, int'(O_ser), 0);
      chk({nm, "_ser_en"}, int'(O_ser_en), 0);
      chk({nm, "_crc_phase"}, int'(O_crc_phase), 0);
      chk({nm, "_busy"}, int'(O_busy), 0);
      chk({nm, "_frame_done"}, int'(O_frame_done), 0);
      chk({nm, "_ready"}, int'(O_ready), 1);
   endtask

   // present a byte, queue its expected bits (and CRC bits if last), return just after acceptance
   task automatic send(input logic [7:0] d, input logic l, input logic [7:0] crc);
      int n = 0;
      I_valid = 1'b1;
      I_data  = d;
      I_last  = l;
      for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b0, 1'b0});
      if (l) for (int i = 7; i >= 0; i--) exp_q.push_back({crc[i], 1'b1, i == 0});
      @(negedge I_clk);
      while (!O_ready && n < 60) begin
         @(negedge I_clk);
         n++;
      end
      chk("accept_timeout", int'(O_ready), 1);
      @(posedge I_clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge I_clk);
         n++;
      end
      chk({nm, "_pending_bits"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge I_clk);
      #1;
   endtask

   initial begin
      int acc;
      int dn0;
      int h0;
      int rdy_hi;
      int n;
      I_rst   = 1'b1;
      I_valid = 1'b0;
      I_data  = '0;
      I_last  = 1'b0;
      #3;
      chk_reset("reset");
      repeat (2) @(posedge I_clk);
      #1;
      I_rst = 1'b0;

      // single byte 0x31 -> CRC 0x97, ready low throughout
      dn0 = done_t.size();
      send(8'h31, 1'b1, 8'h97);
      I_valid = 1'b0;
      acc = cyc;
      rdy_hi = 0;
      repeat (16) begin
         @(negedge I_clk);
         if (O_ready) rdy_hi++;
      end
      chk("single_ready_low", rdy_hi, 0);
      drain("single");
      chk("single_done_count", done_t.size(), dn0 + 1);
      if (done_t.size() > dn0) chk("single_done_time", done_t[dn0], acc + 15);

      // "123456789" back-to-back -> CRC 0xF4, 72 contiguous data bits
      dn0 = done_t.size();
      send(8'h31, 1'b0, 8'h00);
      acc = cyc;
      for (int b = 8'h32; b <= 8'h38; b++) send(8'(b), 1'b0, 8'h00);
      send(8'h39, 1'b1, 8'hF4);
      I_valid = 1'b0;
      drain("check");
      chk("check_done_count", done_t.size(), dn0 + 1);
      if (done_t.size() > dn0) chk("check_done_time", done_t[dn0], acc + 79);

      // 0x01, three HOLD cycles, 0x02 -> CRC of 0x0102 = 0x1B
      dn0 = done_t.size();
      h0 = hold_cnt;
      send(8'h01, 1'b0, 8'h00);
      acc = cyc;
      I_valid = 1'b0;
      repeat (10) @(posedge I_clk);
      #1;
      send(8'h02, 1'b1, 8'h1B);
      I_valid = 1'b0;
      drain("hold");
      chk("hold_cycles", hold_cnt - h0, 3);
      chk("hold_done_count", done_t.size(), dn0 + 1);
      if (done_t.size() > dn0) chk("hold_done_time", done_t[dn0], acc + 26);

      // reset during CRC bit 3 abandons the frame; next frame 0x01 -> 0x07
      dn0 = done_t.size();
      send(8'h31, 1'b1, 8'h97);
      I_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 100 && n < 4; k++) begin
         @(negedge I_clk);
         if (O_crc_phase) n++;
      end
      chk("abort_reach_crc3", n, 4);
      #2;
      I_rst = 1'b1;
      #1;
      chk_reset("abort");
      exp_q.delete();
      @(posedge I_clk);
      #1;
      I_rst = 1'b0;
      send(8'h01, 1'b1, 8'h07);
      I_valid = 1'b0;
      drain("after_abort");
      chk("abort_done_count", done_t.size(), dn0 + 1);

      // valid held high: single-byte frames separated by exactly one IDLE cycle
      dn0 = done_t.size();
      send(8'h01, 1'b1, 8'h07);
      send(8'h31, 1'b1, 8'h97);
      send(8'h02, 1'b1, 8'h0E);
      I_valid = 1'b0;
      drain("stream");
      chk("stream_done_count", done_t.size(), dn0 + 3);
      if (done_t.size() >= dn0 + 3) begin
         chk("stream_gap_1", done_t[dn0 + 1] - done_t[dn0], 17);
         chk("stream_gap_2", done_t[dn0 + 2] - done_t[dn0 + 1], 17);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks + m_checks, fails + m_fails);
      $finish;
   end
endmodule
